// File: rtl/bitwise_logic_pipe.sv
// ---------------------------------------------------------------------------
// bitwise_logic_pipe
//
// Two-stage pipelined bitwise logic unit for the ALU datapath. It sits between
// the register-file read stage and the writeback mux. Operands and op are
// captured in S1. The selected bitwise result, its zero flag and its parity
// flag are captured in S2, which drives the outputs. Both sides use a
// valid/ready handshake with full backpressure. A wrapping counter tracks the
// number of results the consumer has taken.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - X, Y and op are presented
//   in_ready  - unit accepts the input this cycle (combinational from out_ready)
//   X, Y      - operands, WIDTH bits
//   op        - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//               110 ANDN (X & ~Y), 111 PASS (X)
//   out_valid - result presented
//   out_ready - consumer accepts the result this cycle
//   Z         - result, WIDTH bits
//   zero      - Z == 0
//   parity    - XOR-reduction of Z
//   op_count  - results consumed, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module bitwise_logic_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Single-bit slice of the logic unit; every op is independent per bit.
    function automatic logic bit_op(input logic [2:0] sel, input logic a, input logic b);
        logic r;
        case (sel)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = a;         // PASS
        endcase
        return r;
    endfunction

    // Stage 1: operand capture
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_x_reg;
    logic [WIDTH-1:0] s1_y_reg;
    logic [2:0]       s1_op_reg;

    // Stage 2: result capture
    logic             s2_valid_reg;
    logic [WIDTH-1:0] z_reg;
    logic             zero_reg;
    logic             parity_reg;

    logic [CNT_W-1:0] op_count_reg;

    // Handshake control
    logic s2_accept;
    logic s1_advance;
    logic in_xfer;
    logic out_xfer;

    assign s2_accept  = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_accept;
    // Depends only on pipeline state and out_ready, never on in_valid.
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = s2_valid_reg && out_ready;

    // Combinational result computed from S1 contents
    logic [WIDTH-1:0] z_next;
    logic             zero_next;
    logic             parity_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign z_next[gi] = bit_op(s1_op_reg, s1_x_reg[gi], s1_y_reg[gi]);
    end

    assign zero_next   = ~|z_next;
    assign parity_next = ^z_next;

    // S1 register. When S1 advances and a new input arrives on the same edge,
    // the load wins and s1_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            s1_op_reg    <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid_reg <= 1'b1;
                s1_x_reg     <= X;
                s1_y_reg     <= Y;
                s1_op_reg    <= op;
            end else if (s1_advance) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    // S2 register. Result fields only change on an S1 advance, so they hold
    // under backpressure and keep their last value once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            z_reg        <= '0;
            zero_reg     <= 1'b1;
            parity_reg   <= 1'b0;
        end else begin
            if (s1_advance) begin
                s2_valid_reg <= 1'b1;
                z_reg        <= z_next;
                zero_reg     <= zero_next;
                parity_reg   <= parity_next;
            end else if (out_xfer) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (out_xfer) begin
            op_count_reg <= op_count_reg + CNT_ONE;
        end
    end

    assign out_valid = s2_valid_reg;
    assign Z         = z_reg;
    assign zero      = zero_reg;
    assign parity    = parity_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// ---------------------------------------------------------------------------
// tb_bitwise_logic_pipe
//
// Directed bench for bitwise_logic_pipe. dut_a (WIDTH=16, CNT_W=4) covers
// reset, every op, flags, backpressure, reset mid-pipeline and counter wrap.
// dut_b (WIDTH=37, CNT_W=16) runs a randomised handshake stream against a
// scoreboard. Stimulus is driven 1 time unit after the rising edge and
// outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_bitwise_logic_pipe;

    localparam int W1     = 16;
    localparam int C1     = 4;
    localparam int W2     = 37;
    localparam int C2     = 16;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // dut_a signals
    logic          in_valid, in_ready, out_valid, out_ready, zero, parity;
    logic [W1-1:0] x, y, z;
    logic [2:0]    op;
    logic [C1-1:0] op_count;

    // dut_b signals
    logic          in_valid2, in_ready2, out_valid2, out_ready2, zero2, parity2;
    logic [W2-1:0] x2, y2, z2;
    logic [2:0]    op2;
    logic [C2-1:0] op_count2;

    int check_count = 0;
    int pass_count  = 0;
    int exp_cnt     = 0;

    bitwise_logic_pipe #(.WIDTH(W1), .CNT_W(C1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .X(x), .Y(y), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .Z(z), .zero(zero), .parity(parity), .op_count(op_count)
    );

    bitwise_logic_pipe #(.WIDTH(W2), .CNT_W(C2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .X(x2), .Y(y2), .op(op2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .Z(z2), .zero(zero2), .parity(parity2), .op_count(op_count2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W2-1:0] model(input logic [2:0] o, input logic [W2-1:0] a,
                                            input logic [W2-1:0] b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic test_reset;
        in_valid = 0; out_ready = 0; x = '0; y = '0; op = '0;
        in_valid2 = 0; out_ready2 = 0; x2 = '0; y2 = '0; op2 = '0;
        #2 rst_n = 1'b0;
        #10;
        check_count++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_count++;
        check_count++; if (z !== 16'h0000) $display("FAIL reset_z got=%h exp=0000", z); else pass_count++;
        check_count++; if (zero !== 1'b1) $display("FAIL reset_zero got=%b exp=1", zero); else pass_count++;
        check_count++; if (parity !== 1'b0) $display("FAIL reset_parity got=%b exp=0", parity); else pass_count++;
        check_count++; if (op_count !== 4'd0) $display("FAIL reset_op_count got=%0d exp=0", op_count); else pass_count++;
        check_count++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        step;
        check_count++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); else pass_count++;
        check_count++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); else pass_count++;
        exp_cnt = 0;
        $display("test_reset done");
    endtask

    task automatic test_all_ops;
        logic [15:0] exp_z [0:7];
        exp_z[0] = 16'hF000; exp_z[1] = 16'hFFF0; exp_z[2] = 16'h0FF0; exp_z[3] = 16'h0FFF;
        exp_z[4] = 16'h000F; exp_z[5] = 16'hF00F; exp_z[6] = 16'h00F0; exp_z[7] = 16'hF0F0;
        out_ready = 1; x = 16'hF0F0; y = 16'hFF00;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                in_valid = 1; op = i[2:0];
            end else begin
                in_valid = 0;
            end
            step;
            if (i == 0) begin
                check_count++; if (out_valid !== 1'b0) $display("FAIL ops_latency out_valid got=%b exp=0", out_valid); else pass_count++;
            end else begin
                check_count++; if (out_valid !== 1'b1) $display("FAIL ops_valid[%0d] got=%b exp=1", i-1, out_valid); else pass_count++;
                check_count++; if (z !== exp_z[i-1]) $display("FAIL ops_z[%0d] got=%h exp=%h", i-1, z, exp_z[i-1]); else pass_count++;
                check_count++; if (zero !== 1'b0) $display("FAIL ops_zero[%0d] got=%b exp=0", i-1, zero); else pass_count++;
                check_count++; if (parity !== 1'b0) $display("FAIL ops_parity[%0d] got=%b exp=0", i-1, parity); else pass_count++;
                $display("op %0d: Z=%h", i-1, z);
            end
        end
        step;
        exp_cnt += 8;
        check_count++; if (out_valid !== 1'b0) $display("FAIL ops_drain out_valid got=%b exp=0", out_valid); else pass_count++;
        check_count++; if (op_count !== 4'(exp_cnt)) $display("FAIL ops_op_count got=%0d exp=%0d", op_count, exp_cnt % 16); else pass_count++;
    endtask

    task automatic test_flags;
        out_ready = 1;
        in_valid = 1; op = 3'b000; x = 16'h00FF; y = 16'hFF00;
        step;
        op = 3'b010; x = 16'h0001; y = 16'h0000;
        step;
        in_valid = 0;
        check_count++; if (z !== 16'h0000) $display("FAIL flags_and_z got=%h exp=0000", z); else pass_count++;
        check_count++; if (zero !== 1'b1) $display("FAIL flags_and_zero got=%b exp=1", zero); else pass_count++;
        check_count++; if (parity !== 1'b0) $display("FAIL flags_and_parity got=%b exp=0", parity); else pass_count++;
        $display("flags AND: Z=%h zero=%b parity=%b", z, zero, parity);
        step;
        check_count++; if (z !== 16'h0001) $display("FAIL flags_xor_z got=%h exp=0001", z); else pass_count++;
        check_count++; if (zero !== 1'b0) $display("FAIL flags_xor_zero got=%b exp=0", zero); else pass_count++;
        check_count++; if (parity !== 1'b1) $display("FAIL flags_xor_parity got=%b exp=1", parity); else pass_count++;
        $display("flags XOR: Z=%h zero=%b parity=%b", z, zero, parity);
        step;
        exp_cnt += 2;
        check_count++; if (op_count !== 4'(exp_cnt)) $display("FAIL flags_op_count got=%0d exp=%0d", op_count, exp_cnt % 16); else pass_count++;
    endtask

    task automatic test_back_pressure;
        logic [15:0] exp_z [0:4];
        int acc = 0, got = 0, cyc = 0;
        logic in_x, out_x;
        exp_z[0] = 16'h0034; exp_z[1] = 16'h12FF; exp_z[2] = 16'h12CB;
        exp_z[3] = 16'hFFCB; exp_z[4] = 16'hED00;
        out_ready = 0; x = 16'h1234; y = 16'h00FF;
        in_valid = 1; op = 3'd0;
        for (int c = 0; c < 6; c++) begin
            #1;
            in_x = in_valid && in_ready;
            step;
            if (in_x) begin
                acc++;
                op = acc[2:0];
            end
        end
        #1;
        check_count++; if (acc !== 2) $display("FAIL bp_accepts got=%0d exp=2", acc); else pass_count++;
        check_count++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else pass_count++;
        check_count++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", out_valid); else pass_count++;
        check_count++; if (z !== exp_z[0]) $display("FAIL bp_hold_z got=%h exp=%h", z, exp_z[0]); else pass_count++;
        out_ready = 1;
        while (got < 5 && cyc < 50) begin
            in_valid = (acc < 5);
            op = acc[2:0];
            #1;
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (out_x) begin
                check_count++; if (z !== exp_z[got]) $display("FAIL bp_z[%0d] got=%h exp=%h", got, z, exp_z[got]); else pass_count++;
                $display("bp result %0d: Z=%h", got, z);
                got++;
            end
            step;
            if (in_x) acc++;
            cyc++;
        end
        in_valid = 0;
        exp_cnt += 5;
        check_count++; if (got !== 5) $display("FAIL bp_delivered got=%0d exp=5", got); else pass_count++;
        check_count++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup out_valid got=%b exp=0", out_valid); else pass_count++;
        check_count++; if (op_count !== 4'(exp_cnt)) $display("FAIL bp_op_count got=%0d exp=%0d", op_count, exp_cnt % 16); else pass_count++;
    endtask

    task automatic test_reset_mid;
        out_ready = 0; in_valid = 1; x = 16'hAAAA; y = 16'h5555; op = 3'b001;
        step;
        step;
        in_valid = 0;
        check_count++; if (out_valid !== 1'b1) $display("FAIL rm_in_flight got=%b exp=1", out_valid); else pass_count++;
        #2 rst_n = 1'b0;
        #1;
        check_count++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid got=%b exp=0", out_valid); else pass_count++;
        check_count++; if (z !== 16'h0000) $display("FAIL rm_z got=%h exp=0000", z); else pass_count++;
        check_count++; if (zero !== 1'b1) $display("FAIL rm_zero got=%b exp=1", zero); else pass_count++;
        check_count++; if (op_count !== 4'd0) $display("FAIL rm_op_count got=%0d exp=0", op_count); else pass_count++;
        check_count++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got=%b exp=1", in_ready); else pass_count++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        check_count++; if (in_ready !== 1'b1) $display("FAIL rm_release_in_ready got=%b exp=1", in_ready); else pass_count++;
        in_valid = 1; op = 3'b000; x = 16'hFFFF; y = 16'hAAAA; out_ready = 1;
        step;
        in_valid = 0;
        step;
        check_count++; if (out_valid !== 1'b1) $display("FAIL rm_new_valid got=%b exp=1", out_valid); else pass_count++;
        check_count++; if (z !== 16'hAAAA) $display("FAIL rm_new_z got=%h exp=aaaa", z); else pass_count++;
        check_count++; if (parity !== 1'b0) $display("FAIL rm_new_parity got=%b exp=0", parity); else pass_count++;
        $display("reset mid: new op Z=%h", z);
        step;
        exp_cnt = 1;
        check_count++; if (op_count !== 4'(exp_cnt)) $display("FAIL rm_op_count_after got=%0d exp=1", op_count); else pass_count++;
    endtask

    task automatic test_wrap;
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        out_ready = 1; in_valid = 1; op = 3'b111;
        for (int i = 0; i < 17; i++) begin
            x = 16'(i);
            step;
        end
        in_valid = 0;
        step;
        step;
        check_count++; if (op_count !== 4'd1) $display("FAIL wrap_op_count got=%0d exp=1", op_count); else pass_count++;
        check_count++; if (out_valid !== 1'b0) $display("FAIL wrap_drained got=%b exp=0", out_valid); else pass_count++;
        $display("wrap: op_count=%0d after 17 transfers", op_count);
    endtask

    task automatic test_random;
        logic [W2-1:0] q[$];
        logic [W2-1:0] e;
        logic [63:0]   r;
        logic          in_x, out_x;
        int sent = 0, got = 0, cyc = 0;
        in_valid2 = 0; out_ready2 = 0;
        while (got < N_RAND && cyc < 60000) begin
            if (!in_valid2 && sent < N_RAND && $urandom_range(3) != 0) begin
                in_valid2 = 1;
                r = {$urandom(), $urandom()}; x2 = r[W2-1:0];
                r = {$urandom(), $urandom()}; y2 = r[W2-1:0];
                op2 = 3'($urandom_range(7));
            end
            out_ready2 = ($urandom_range(3) != 0);
            #1;
            in_x  = in_valid2 && in_ready2;
            out_x = out_valid2 && out_ready2;
            if (out_x) begin
                if (q.size() == 0) begin
                    check_count++;
                    $display("FAIL rand_spurious got=%h exp=none", z2);
                end else begin
                    e = q.pop_front();
                    check_count++; if (z2 !== e) $display("FAIL rand_z[%0d] got=%h exp=%h", got, z2, e); else pass_count++;
                    check_count++; if (zero2 !== (e == '0)) $display("FAIL rand_zero[%0d] got=%b exp=%b", got, zero2, (e == '0)); else pass_count++;
                    check_count++; if (parity2 !== ^e) $display("FAIL rand_parity[%0d] got=%b exp=%b", got, parity2, ^e); else pass_count++;
                end
                got++;
            end
            if (in_x) begin
                q.push_back(model(op2, x2, y2));
                sent++;
            end
            step;
            if (in_x) in_valid2 = 0;
            cyc++;
        end
        in_valid2 = 0;
        check_count++; if (got !== N_RAND) $display("FAIL rand_count got=%0d exp=%0d", got, N_RAND); else pass_count++;
        check_count++; if (q.size() !== 0) $display("FAIL rand_leftover got=%0d exp=0", q.size()); else pass_count++;
        check_count++; if (op_count2 !== 16'(N_RAND)) $display("FAIL rand_op_count got=%0d exp=%0d", op_count2, N_RAND); else pass_count++;
        $display("random: %0d results in %0d cycles", got, cyc);
    endtask

    initial begin
        test_reset;
        test_all_ops;
        test_flags;
        test_back_pressure;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
